// File: rtl/game_pkg.sv
// Shared definitions for the board-game turn sequencer.
// Holds the display state codes, the "no key" keypad code and the
// player-count range check used when a game is (re)started.
package game_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_SELECT    = 4'd1;
  localparam logic [3:0] ST_SETUP     = 4'd2;
  localparam logic [3:0] ST_WAIT_PICK = 4'd3;
  localparam logic [3:0] ST_EVAL      = 4'd4;
  localparam logic [3:0] ST_PASS      = 4'd5;
  localparam logic [3:0] ST_MOVE      = 4'd6;
  localparam logic [3:0] ST_CHECK     = 4'd7;
  localparam logic [3:0] ST_WIN       = 4'd8;

  localparam int unsigned KEY_NONE = 0;

  typedef enum logic [3:0] {
    S_IDLE      = ST_IDLE,
    S_SELECT    = ST_SELECT,
    S_SETUP     = ST_SETUP,
    S_WAIT_PICK = ST_WAIT_PICK,
    S_EVAL      = ST_EVAL,
    S_PASS      = ST_PASS,
    S_MOVE      = ST_MOVE,
    S_CHECK     = ST_CHECK,
    S_WIN       = ST_WIN
  } state_t;

  // True when a keypad code is an acceptable player count.
  function automatic logic count_ok(input int unsigned k,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (k >= lo) && (k <= hi);
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-pick timeout counter.
// Ports: clk, rst (sync, active high); clr restarts the count; en advances it
// by one per cycle (saturating at CYC); expire is combinational and high while
// en is set and the count sits at CYC-1. CYC=0 removes the timer entirely.
module turn_timer #(
  parameter int unsigned CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (CYC == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(CYC + 1);

      logic [CW-1:0] count;

      // Saturating cycle counter; never wraps back to zero on its own.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          count <= '0;
        end else if (en && (count != CW'(CYC))) begin
          count <= count + CW'(1);
        end
      end

      assign expire = en && (count == CW'(CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn/round sequencer between the keypad/card-match logic and the board
// display. Latches the player count, runs pick / evaluate / move / win-check,
// rotates the active player on a miss and restarts from the win state.
// Ports: clk, rst (sync, active high); start, key, go, win inputs;
// registered outputs state, num_players, cur_player, prompt, advance,
// turn_end, timeout, winner, done.
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter  int unsigned MAX_PLAYERS = 4,
  parameter  int unsigned MIN_PLAYERS = 2,
  parameter  int unsigned KEY_W       = 4,
  parameter  int unsigned TIMEOUT_CYC = 50_000_000,
  localparam int unsigned PW = ($clog2(MAX_PLAYERS) < 1) ? 1 : $clog2(MAX_PLAYERS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             go,
  input  logic             win,
  output logic [3:0]       state,
  output logic [PW:0]      num_players,
  output logic [PW-1:0]    cur_player,
  output logic             prompt,
  output logic             advance,
  output logic             turn_end,
  output logic             timeout,
  output logic [PW-1:0]    winner,
  output logic             done
);

  state_t          state_q;
  state_t          state_d;
  logic            armed_q;
  logic            armed_d;
  logic [PW:0]     num_d;
  logic [PW-1:0]   cur_d;
  logic [PW-1:0]   winner_d;
  logic            timeout_d;
  logic            expire;
  logic            key_idle;
  logic            pick;
  logic            last_player;

  assign key_idle    = (key == KEY_W'(KEY_NONE));
  assign pick        = armed_q && !key_idle;
  assign last_player = ({1'b0, cur_player} == (num_players - (PW+1)'(1)));

  // Timer only runs while waiting for a pick; every other state holds it at zero.
  turn_timer #(
    .CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != S_WAIT_PICK),
    .en     (state_q == S_WAIT_PICK),
    .expire (expire)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    num_d     = num_players;
    cur_d     = cur_player;
    winner_d  = winner;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (count_ok(32'(key), MIN_PLAYERS, MAX_PLAYERS)) begin
          num_d   = (PW+1)'(key);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cur_d   = '0;
        armed_d = 1'b0;
        state_d = S_WAIT_PICK;
      end
      S_WAIT_PICK: begin
        // A pick needs a key release first; a pick beats a same-cycle expiry.
        if (pick) begin
          armed_d = 1'b0;
          state_d = S_EVAL;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = S_PASS;
        end else if (key_idle) begin
          armed_d = 1'b1;
        end
      end
      S_EVAL: begin
        state_d = go ? S_MOVE : S_PASS;
      end
      S_PASS: begin
        cur_d   = last_player ? '0 : cur_player + PW'(1);
        armed_d = 1'b0;
        state_d = S_WAIT_PICK;
      end
      S_MOVE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (win) begin
          winner_d = cur_player;
          state_d  = S_WIN;
        end else begin
          armed_d = 1'b0;
          state_d = S_WAIT_PICK;
        end
      end
      S_WIN: begin
        if (start) state_d = S_SELECT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; flags are decoded from the next state so
  // they line up with the state code they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      num_players <= '0;
      cur_player  <= '0;
      winner      <= '0;
      prompt      <= 1'b0;
      advance     <= 1'b0;
      turn_end    <= 1'b0;
      timeout     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      num_players <= num_d;
      cur_player  <= cur_d;
      winner      <= winner_d;
      prompt      <= (state_d == S_WAIT_PICK);
      advance     <= (state_d == S_MOVE);
      turn_end    <= (state_d == S_PASS);
      timeout     <= timeout_d;
      done        <= (state_d == S_WIN);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Bench for game_turn_ctrl: directed scenario steps followed by random
// stimulus, every cycle compared against a behavioural reference model.
module tb_game_turn_ctrl;

  localparam int unsigned MAXP = 4;
  localparam int unsigned MINP = 2;
  localparam int unsigned KW   = 4;
  localparam int unsigned TO   = 8;
  localparam int unsigned PW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] key;
  logic          go;
  logic          win;
  logic [3:0]    state;
  logic [PW:0]   num_players;
  logic [PW-1:0] cur_player;
  logic          prompt;
  logic          advance;
  logic          turn_end;
  logic          timeout;
  logic [PW-1:0] winner;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: state code, count, player, arming, pick timer, pulse.
  int m_state  = 0;
  int m_num    = 0;
  int m_cur    = 0;
  int m_armed  = 0;
  int m_timer  = 0;
  int m_winner = 0;
  int m_to     = 0;

  game_turn_ctrl #(
    .MAX_PLAYERS (MAXP),
    .MIN_PLAYERS (MINP),
    .KEY_W       (KW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key         (key),
    .go          (go),
    .win         (win),
    .state       (state),
    .num_players (num_players),
    .cur_player  (cur_player),
    .prompt      (prompt),
    .advance     (advance),
    .turn_end    (turn_end),
    .timeout     (timeout),
    .winner      (winner),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input int k, input bit g, input bit w);
    m_to = 0;
    if (r) begin
      m_state = 0; m_num = 0; m_cur = 0; m_armed = 0; m_timer = 0; m_winner = 0;
    end else begin
      case (m_state)
        0: if (s) m_state = 1;
        1: if (k >= int'(MINP) && k <= int'(MAXP)) begin
             m_num = k;
             m_state = 2;
           end
        2: begin
             m_cur = 0; m_armed = 0; m_timer = 0; m_state = 3;
           end
        3: begin
             if (m_armed != 0 && k != 0) begin
               m_armed = 0;
               m_state = 4;
             end else if (TO > 0 && m_timer == int'(TO) - 1) begin
               m_to = 1;
               m_state = 5;
             end else if (k == 0) begin
               m_armed = 1;
             end
             if (m_timer < int'(TO)) m_timer++;
           end
        4: m_state = g ? 6 : 5;
        5: begin
             m_cur = (m_cur + 1) % m_num;
             m_armed = 0; m_timer = 0; m_state = 3;
           end
        6: m_state = 7;
        7: if (w) begin
             m_winner = m_cur;
             m_state = 8;
           end else begin
             m_timer = 0; m_armed = 0; m_state = 3;
           end
        8: if (s) m_state = 1;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic check_all();
    chk("state",       32'(state),       32'(m_state));
    chk("num_players", 32'(num_players), 32'(m_num));
    chk("cur_player",  32'(cur_player),  32'(m_cur));
    chk("winner",      32'(winner),      32'(m_winner));
    chk("prompt",      32'(prompt),      (m_state == 3) ? 32'd1 : 32'd0);
    chk("advance",     32'(advance),     (m_state == 6) ? 32'd1 : 32'd0);
    chk("turn_end",    32'(turn_end),    (m_state == 5) ? 32'd1 : 32'd0);
    chk("timeout",     32'(timeout),     32'(m_to));
    chk("done",        32'(done),        (m_state == 8) ? 32'd1 : 32'd0);
  endtask

  // One clock cycle: drive inputs, clock, advance model, compare after the edge.
  task automatic step(input bit r, input bit s, input int k, input bit g, input bit w);
    rst = r; start = s; key = KW'(k); go = g; win = w;
    @(posedge clk);
    model_step(r, s, k, g, w);
    #1;
    check_all();
  endtask

  // Release, pick, miss, back to waiting.
  task automatic miss();
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = '0; go = 1'b0; win = 1'b0;

    // Reset and player-count selection
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_state", 32'(state), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("enter_select", 32'(state), 32'd1);
    step(0, 0, 5, 0, 0);
    chk("select_reject5", 32'(state), 32'd1);
    step(0, 0, 3, 0, 0);
    chk("setup_state", 32'(state), 32'd2);
    chk("latched_num", 32'(num_players), 32'd3);
    step(0, 0, 3, 0, 0);
    chk("wait_prompt", 32'(prompt), 32'd1);
    chk("wait_cur0", 32'(cur_player), 32'd0);

    // Key held from selection must not count as a pick
    step(0, 0, 3, 0, 0);
    step(0, 0, 3, 0, 0);
    chk("unarmed_hold", 32'(state), 32'd3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 7, 0, 0);
    chk("armed_pick_eval", 32'(state), 32'd4);
    chk("armed_pick_prompt", 32'(prompt), 32'd0);

    // Rotation on misses: 0 -> 1 -> 2 -> 0
    step(0, 0, 0, 0, 0);
    chk("miss_turn_end", 32'(turn_end), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("rot_1", 32'(cur_player), 32'd1);
    miss();
    chk("rot_2", 32'(cur_player), 32'd2);
    miss();
    chk("rot_wrap0", 32'(cur_player), 32'd0);

    // Hit without win keeps the turn
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("hit_advance", 32'(advance), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("advance_one_cycle", 32'(advance), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("hit_same_player", 32'(cur_player), 32'd0);
    chk("hit_back_wait", 32'(state), 32'd3);

    // Miss to player 1, then player 1 wins
    miss();
    step(0, 0, 0, 0, 0);
    step(0, 0, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("win_done", 32'(done), 32'd1);
    chk("win_winner", 32'(winner), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("win_hold", 32'(state), 32'd8);
    step(0, 1, 0, 0, 0);
    chk("restart_select", 32'(state), 32'd1);
    chk("restart_done0", 32'(done), 32'd0);

    // Two players; full timeout
    step(0, 0, 2, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    chk("pre_timeout", 32'(timeout), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("timeout_pulse", 32'(timeout), 32'd1);
    chk("timeout_pass", 32'(state), 32'd5);
    step(0, 0, 0, 0, 0);
    chk("timeout_rot", 32'(cur_player), 32'd1);
    chk("timeout_one_cycle", 32'(timeout), 32'd0);

    // Pick landing on the expiry cycle wins
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 5, 0, 0);
    chk("pick_beats_expiry", 32'(state), 32'd4);
    chk("no_timeout_on_pick", 32'(timeout), 32'd0);

    // Reset in MOVE
    step(0, 0, 0, 1, 0);
    chk("in_move", 32'(state), 32'd6);
    step(1, 0, 0, 0, 0);
    chk("midreset_state", 32'(state), 32'd0);
    chk("midreset_advance", 32'(advance), 32'd0);
    chk("midreset_num", 32'(num_players), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit r, s, g, w;
      int k;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      k = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 15));
      g = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0);
      step(r, s, k, g, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
